// File: rtl/lsu_mmio_param.sv
// Load/store unit for a word-organised data memory plus a memory-mapped IO block
// (LED, hex and LCD output registers, switch readback) with configurable wait states.
module lsu_mmio_param #(
  parameter int unsigned ADDR_W      = 11,
  parameter int unsigned DMEM_WORDS  = 256,
  parameter int unsigned NUM_HEX     = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  input  logic [31:0]           sw,
  output logic [31:0]           io_ledr,
  output logic [31:0]           io_ledg,
  output logic [31:0]           io_lcd,
  output logic [NUM_HEX*32-1:0] io_hex
);
  localparam int unsigned IDX_W      = $clog2(DMEM_WORDS);
  localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);
  localparam logic [31:0] A_LEDR     = 32'h400;
  localparam logic [31:0] A_LEDG     = 32'h410;
  localparam logic [31:0] A_HEX      = 32'h420;
  localparam logic [31:0] A_LCD      = 32'h440;
  localparam logic [31:0] A_SW       = 32'h500;
  localparam logic [3:0]  WAIT_INIT  = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               ready_q;
  logic               accept_c, enter_resp_c;

  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic [31:0]        wdata_q;
  logic               stg_err_q;
  logic [31:0]        stg_rdata_q;
  logic [31:0]        dmem_q [DMEM_WORDS];

  logic               a_we, a_uns;
  logic [ADDR_W-1:0]  a_addr;
  logic [1:0]         a_size, lane;
  logic [31:0]        a_wdata, a32, wa;
  logic [IDX_W-1:0]   didx;
  logic               hit_dmem, hit_ledr, hit_ledg, hit_lcd, hit_sw, hit_hex;
  logic               misalign, fault_c;
  logic [NUM_HEX-1:0] hex_sel;
  logic [3:0]         bmask;
  logic [31:0]        wmask, wrep, rword, merged, load_c;
  logic [15:0]        shifted;

  assign req_ready = ready_q;
  assign accept_c  = req_valid & ready_q;

  // Access being resolved: with zero wait states it completes on the accepting edge,
  // so the live request is used while idle, the latched copy otherwise.
  always_comb begin
    if (state_q == S_IDLE) begin
      a_we = req_we; a_addr = req_addr; a_size = req_size; a_uns = req_unsigned; a_wdata = req_wdata;
    end else begin
      a_we = we_q; a_addr = addr_q; a_size = size_q; a_uns = uns_q; a_wdata = wdata_q;
    end
    a32      = 32'(a_addr);
    wa       = {a32[31:2], 2'b00};
    lane     = a32[1:0];
    didx     = a_addr[IDX_W+1:2];
    hit_dmem = (wa < DMEM_BYTES);
    hit_ledr = (wa == A_LEDR);
    hit_ledg = (wa == A_LEDG);
    hit_lcd  = (wa == A_LCD);
    hit_sw   = (wa == A_SW);
    hex_sel  = '0;
    rword    = '0;
    for (int i = 0; i < int'(NUM_HEX); i++) begin
      if (wa == A_HEX + 32'(4 * i)) begin
        hex_sel[i] = 1'b1;
        rword      = io_hex[32*i +: 32];
      end
    end
    hit_hex = |hex_sel;
    if (hit_dmem)      rword = dmem_q[didx];
    else if (hit_ledr) rword = io_ledr;
    else if (hit_ledg) rword = io_ledg;
    else if (hit_lcd)  rword = io_lcd;
    else if (hit_sw)   rword = sw;

    misalign = ((a_size == 2'b01) && lane[0]) || ((a_size == 2'b10) && (lane != 2'b00));
    fault_c  = (a_size == 2'b11) || misalign ||
               !(hit_dmem || hit_ledr || hit_ledg || hit_lcd || hit_sw || hit_hex) ||
               (a_we && hit_sw);

    case (a_size)
      2'b00:   begin bmask = 4'b0001 << lane;               wrep = {4{a_wdata[7:0]}};  end
      2'b01:   begin bmask = lane[1] ? 4'b1100 : 4'b0011;   wrep = {2{a_wdata[15:0]}}; end
      default: begin bmask = 4'b1111;                       wrep = a_wdata;            end
    endcase
    wmask  = {{8{bmask[3]}}, {8{bmask[2]}}, {8{bmask[1]}}, {8{bmask[0]}}};
    merged = (rword & ~wmask) | (wrep & wmask);

    shifted = 16'(rword >> {lane, 3'b000});
    case (a_size)
      2'b00:   load_c = a_uns ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_c = a_uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_c = rword;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    enter_resp_c = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          if (WAIT_INIT == 4'd0) begin
            state_d      = S_RESP;
            enter_resp_c = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d      = S_RESP;
          cnt_d        = '0;
          enter_resp_c = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, IO registers and response pipeline; the response is staged on
  // entry to RESP and presented on the following edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      stg_err_q   <= 1'b0;
      stg_rdata_q <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      io_ledr     <= '0;
      io_ledg     <= '0;
      io_lcd      <= '0;
      io_hex      <= '0;
    end else begin
      ready_q <= (state_d == S_IDLE);
      if (accept_c) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
      end
      if (enter_resp_c) begin
        stg_err_q   <= fault_c;
        stg_rdata_q <= (fault_c || a_we) ? '0 : load_c;
        if (a_we && !fault_c) begin
          if (hit_ledr) io_ledr <= merged;
          if (hit_ledg) io_ledg <= merged;
          if (hit_lcd)  io_lcd  <= merged;
          for (int i = 0; i < int'(NUM_HEX); i++) begin
            if (hex_sel[i]) io_hex[32*i +: 32] <= merged;
          end
        end
      end
      resp_valid <= (state_q == S_RESP);
      resp_rdata <= (state_q == S_RESP) ? stg_rdata_q : '0;
      resp_err   <= (state_q == S_RESP) && stg_err_q;
    end
  end

  // Data memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (enter_resp_c && a_we && !fault_c && hit_dmem) dmem_q[didx] <= merged;
  end

endmodule

// File: tb/tb_lsu_mmio_param.sv
// Bench for lsu_mmio_param: three instances (0, 1 and 3 wait states) checked against
// a byte-addressed behavioural model of the memory map.
module tb_lsu_mmio_param;
  logic        clk = 1'b0;
  logic        rst;
  logic        rv [3];
  logic        we [3];
  logic        uns [3];
  logic [10:0] ad [3];
  logic [1:0]  sz [3];
  logic [31:0] wd [3];
  logic        rr [3];
  logic        rvo [3];
  logic        re [3];
  logic [31:0] rd [3];
  logic [31:0] ledr [3];
  logic [31:0] ledg [3];
  logic [31:0] lcd [3];
  logic [255:0] hx [3];
  logic [31:0] sw_in;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mb [0:2047];
  bit         kn [0:2047];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    lsu_mmio_param #(
      .ADDR_W(11), .DMEM_WORDS(256), .NUM_HEX(8),
      .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(rv[g]), .req_ready(rr[g]), .req_we(we[g]), .req_addr(ad[g]),
      .req_size(sz[g]), .req_unsigned(uns[g]), .req_wdata(wd[g]),
      .resp_valid(rvo[g]), .resp_rdata(rd[g]), .resp_err(re[g]),
      .sw(sw_in), .io_ledr(ledr[g]), .io_ledg(ledg[g]), .io_lcd(lcd[g]), .io_hex(hx[g])
    );
  end

  function automatic int wl(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  function automatic logic [31:0] mw(input int a);
    return {mb[a+3], mb[a+2], mb[a+1], mb[a]};
  endfunction

  function automatic logic [351:0] mio();
    logic [255:0] h;
    for (int i = 0; i < 8; i++) h[32*i +: 32] = mw('h420 + 4*i);
    return {mw('h400), mw('h410), mw('h440), h};
  endfunction

  function automatic void model_io_reset();
    for (int a = 'h400; a < 'h480; a++) begin mb[a] = 8'h00; kn[a] = 1'b1; end
  endfunction

  // Reference: apply one access to the byte-level model; chk=0 when a load touches unwritten DMEM.
  function automatic void mdl(input bit w, input logic [10:0] a, input logic [1:0] s, input bit u,
                              input logic [31:0] d_in, output logic [31:0] r, output bit err, output bit chk);
    int ai, n, wa;
    bit mapped;
    logic [31:0] v;
    ai = int'(a);
    n  = (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
    wa = ai - (ai % 4);
    mapped = (wa < 'h400) || (wa == 'h400) || (wa == 'h410) || (wa >= 'h420 && wa < 'h440) ||
             (wa == 'h440) || (wa == 'h500);
    err = (s == 2'd3) || ((ai % n) != 0) || !mapped || (w && wa == 'h500);
    r   = '0;
    chk = 1'b1;
    if (err) return;
    if (w) begin
      for (int i = 0; i < n; i++) begin mb[ai+i] = d_in[8*i +: 8]; kn[ai+i] = 1'b1; end
      return;
    end
    v = '0;
    for (int i = 0; i < n; i++) begin
      if (wa == 'h500) v[8*i +: 8] = sw_in[8*((ai % 4) + i) +: 8];
      else begin v[8*i +: 8] = mb[ai+i]; if (!kn[ai+i]) chk = 1'b0; end
    end
    if (n == 1)      r = u ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
    else if (n == 2) r = u ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    else             r = v;
  endfunction

  task automatic idle_inputs();
    for (int d = 0; d < 3; d++) begin
      rv[d] = 1'b0; we[d] = 1'b0; uns[d] = 1'b0; ad[d] = '0; sz[d] = 2'd2; wd[d] = '0;
    end
  endtask

  // One access on all three instances; spec[32] set overrides the model's load value.
  task automatic txn(input string nm, input bit w, input logic [10:0] a, input logic [1:0] s,
                     input bit u, input logic [31:0] d_in, input logic [32:0] spec);
    logic [31:0] erd;
    bit eerr, chk;
    bit got [3], dup [3], dirty [3], gerr [3];
    int lat [3];
    logic [31:0] grd [3];
    mdl(w, a, s, u, d_in, erd, eerr, chk);
    if (spec[32]) begin erd = spec[31:0]; chk = 1'b1; end
    for (int d = 0; d < 3; d++) begin
      got[d] = 0; dup[d] = 0; dirty[d] = 0; gerr[d] = 0; lat[d] = 0; grd[d] = '0;
      n_cmp++;
      if (rr[d] !== 1'b1) begin n_bad++; $display("FAIL %s dut%0d ready_before got %b want 1", nm, d, rr[d]); end
      rv[d] = 1'b1; we[d] = w; ad[d] = a; sz[d] = s; uns[d] = u; wd[d] = d_in;
    end
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      rv[d] = 1'b0; we[d] = 1'($urandom); ad[d] = 11'($urandom); sz[d] = 2'($urandom);
      uns[d] = 1'($urandom); wd[d] = $urandom;
    end
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        if (rvo[d] === 1'b1) begin
          if (got[d]) dup[d] = 1;
          else begin got[d] = 1; lat[d] = c; grd[d] = rd[d]; gerr[d] = re[d]; end
        end else if (rd[d] !== 32'd0 || re[d] !== 1'b0) dirty[d] = 1;
      end
    end
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (!got[d]) begin n_bad++; $display("FAIL %s dut%0d resp_timeout got none want resp_valid", nm, d); end
      else begin
        n_cmp++;
        if (lat[d] != wl(d) + 1) begin n_bad++; $display("FAIL %s dut%0d latency got %0d want %0d", nm, d, lat[d], wl(d) + 1); end
        n_cmp++;
        if (gerr[d] !== eerr) begin n_bad++; $display("FAIL %s dut%0d err got %b want %b", nm, d, gerr[d], eerr); end
        if (chk) begin
          n_cmp++;
          if (grd[d] !== erd) begin n_bad++; $display("FAIL %s dut%0d rdata got %h want %h", nm, d, grd[d], erd); end
        end
      end
      n_cmp++;
      if (dup[d]) begin n_bad++; $display("FAIL %s dut%0d duplicate_resp got 1 want 0", nm, d); end
      n_cmp++;
      if (dirty[d]) begin n_bad++; $display("FAIL %s dut%0d idle_resp_nonzero got 1 want 0", nm, d); end
      n_cmp++;
      if ({ledr[d], ledg[d], lcd[d], hx[d]} !== mio()) begin
        n_bad++; $display("FAIL %s dut%0d io_regs got %h want %h", nm, d, {ledr[d], ledg[d], lcd[d], hx[d]}, mio());
      end
    end
  endtask

  task automatic test_reset();
    bit seen [3];
    idle_inputs();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if ({rr[d], rvo[d], re[d], rd[d], ledr[d], ledg[d], lcd[d], hx[d]} !== '0) begin
        n_bad++; $display("FAIL reset_state dut%0d got ready=%b valid=%b err=%b rdata=%h ledr=%h want all 0",
                          d, rr[d], rvo[d], re[d], rd[d], ledr[d]);
      end
    end
    rst = 1'b1;
    model_io_reset();
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (rr[d] !== 1'b1) begin n_bad++; $display("FAIL reset_ready dut%0d got %b want 1", d, rr[d]); end
      rv[d] = 1'b1; we[d] = 1'b1; ad[d] = 11'h400; sz[d] = 2'd2; wd[d] = 32'h12345678;
    end
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (ledr[d] !== 32'd0) begin n_bad++; $display("FAIL abort_async_ledr dut%0d got %h want 0", d, ledr[d]); end
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) seen[d] = 0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (rr[d] !== 1'b1) begin n_bad++; $display("FAIL abort_ready dut%0d got %b want 1", d, rr[d]); end
    end
    repeat (6) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) if (rvo[d] !== 1'b0) seen[d] = 1;
    end
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (seen[d] || ledr[d] !== 32'd0) begin
        n_bad++; $display("FAIL abort_no_commit dut%0d got resp=%b ledr=%h want resp=0 ledr=0", d, seen[d], ledr[d]);
      end
    end
  endtask

  task automatic test_latency();
    txn("sw_dmem", 1, 11'h010, 2'd2, 0, 32'hDEADBEEF, 33'd0);
    txn("lw_dmem", 0, 11'h010, 2'd2, 0, 32'd0, {1'b1, 32'hDEADBEEF});
  endtask

  task automatic test_byte_lanes();
    txn("sw_base", 1, 11'h010, 2'd2, 0, 32'h11223344, 33'd0);
    txn("sb_lane3", 1, 11'h013, 2'd0, 0, 32'h00000080, 33'd0);
    txn("lw_merged", 0, 11'h010, 2'd2, 1, 32'd0, {1'b1, 32'h80223344});
    txn("lb_sext", 0, 11'h013, 2'd0, 0, 32'd0, {1'b1, 32'hFFFFFF80});
    txn("lbu_zext", 0, 11'h013, 2'd0, 1, 32'd0, {1'b1, 32'h00000080});
    txn("lh_sext", 0, 11'h012, 2'd1, 0, 32'd0, {1'b1, 32'hFFFF8022});
    txn("sh_lane0", 1, 11'h010, 2'd1, 0, 32'hABCD7E01, 33'd0);
    txn("lhu_lane0", 0, 11'h010, 2'd1, 1, 32'd0, {1'b1, 32'h00007E01});
  endtask

  task automatic test_io_map();
    txn("sw_hex3", 1, 11'h42C, 2'd2, 0, 32'h0000003F, 33'd0);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (hx[d] !== {128'd0, 32'h3F, 96'd0}) begin n_bad++; $display("FAIL hex3_only dut%0d got %h want hex3=3f", d, hx[d]); end
    end
    sw_in = 32'hA5A5A5A5;
    txn("lw_sw", 0, 11'h500, 2'd2, 0, 32'd0, {1'b1, 32'hA5A5A5A5});
    txn("lh_sw_hi", 0, 11'h502, 2'd1, 0, 32'd0, {1'b1, 32'hFFFFA5A5});
    txn("sw_ledr", 1, 11'h400, 2'd2, 0, 32'hCAFEF00D, 33'd0);
    txn("sb_ledg1", 1, 11'h411, 2'd0, 0, 32'h0000005A, 33'd0);
    txn("sh_lcd2", 1, 11'h442, 2'd1, 0, 32'h00008123, 33'd0);
    txn("lw_ledr_rb", 0, 11'h400, 2'd2, 0, 32'd0, {1'b1, 32'hCAFEF00D});
    txn("lbu_ledg_rb", 0, 11'h411, 2'd0, 1, 32'd0, {1'b1, 32'h0000005A});
    txn("lw_lcd_rb", 0, 11'h440, 2'd2, 0, 32'd0, {1'b1, 32'h81230000});
    txn("sw_hex7", 1, 11'h43C, 2'd2, 0, 32'h00000079, 33'd0);
  endtask

  task automatic test_faults();
    txn("lw_mis", 0, 11'h402, 2'd2, 0, 32'd0, {1'b1, 32'd0});
    txn("sh_mis", 1, 11'h011, 2'd1, 0, 32'h0000FFFF, {1'b1, 32'd0});
    txn("sw_to_sw", 1, 11'h500, 2'd2, 0, 32'h01020304, {1'b1, 32'd0});
    txn("lw_unmap", 0, 11'h600, 2'd2, 0, 32'd0, {1'b1, 32'd0});
    txn("sw_unmap", 1, 11'h404, 2'd2, 0, 32'h55555555, {1'b1, 32'd0});
    txn("size11", 1, 11'h010, 2'd3, 0, 32'h99999999, {1'b1, 32'd0});
    txn("dmem_kept", 0, 11'h010, 2'd2, 0, 32'd0, 33'd0);
  endtask

  task automatic test_random();
    logic [10:0] a;
    for (int k = 0; k < 70; k++) begin
      case ($urandom_range(0, 7))
        0, 7:    a = 11'($urandom_range(0, 'h3FF));
        1:       a = 11'('h400 + $urandom_range(0, 3));
        2:       a = 11'('h410 + $urandom_range(0, 3));
        3:       a = 11'('h420 + $urandom_range(0, 31));
        4:       a = 11'('h440 + $urandom_range(0, 3));
        5:       a = 11'('h500 + $urandom_range(0, 3));
        default: a = 11'($urandom);
      endcase
      if ((k % 10) == 0) sw_in = $urandom;
      txn("random", 1'($urandom), a, 2'($urandom), 1'($urandom), $urandom, 33'd0);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] fq [3][64];
    int hd [3], tl [3], acc [3], nresp [3], last [3], nxt [3], bad_iv [3], bad_rd [3], bad_dup [3];
    bit pre [3];
    logic [31:0] erd;
    bit eerr, chk;
    for (int k = 0; k < 16; k++) txn("prefill", 1, 11'('h100 + 4*k), 2'd2, 0, $urandom, 33'd0);
    for (int d = 0; d < 3; d++) begin
      hd[d] = 0; tl[d] = 0; acc[d] = 0; nresp[d] = 0; last[d] = 0; nxt[d] = 0;
      bad_iv[d] = 0; bad_rd[d] = 0; bad_dup[d] = 0;
      rv[d] = 1'b1; we[d] = 1'b0; sz[d] = 2'd2; uns[d] = 1'b0; ad[d] = 11'h100;
    end
    for (int cyc = 0; cyc < 48; cyc++) begin
      if (cyc == 40) for (int d = 0; d < 3; d++) rv[d] = 1'b0;
      for (int d = 0; d < 3; d++) pre[d] = rr[d];
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        if (rvo[d] === 1'b1) begin
          if (hd[d] == tl[d]) bad_dup[d]++;
          else begin
            mdl(0, fq[d][hd[d]], 2'd2, 0, 32'd0, erd, eerr, chk);
            if (rd[d] !== erd || re[d] !== 1'b0) bad_rd[d]++;
            hd[d]++; nresp[d]++;
          end
        end
        if (pre[d] && rv[d]) begin
          if (acc[d] > 0 && (cyc - last[d]) != wl(d) + 2) bad_iv[d]++;
          acc[d]++; last[d] = cyc;
          fq[d][tl[d]] = ad[d]; tl[d]++;
          nxt[d]++;
          ad[d] = 11'('h100 + 4*(nxt[d] % 16));
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (acc[d] != (40 + wl(d) + 1) / (wl(d) + 2)) begin
        n_bad++; $display("FAIL b2b_accepts dut%0d got %0d want %0d", d, acc[d], (40 + wl(d) + 1) / (wl(d) + 2));
      end
      n_cmp++;
      if (bad_iv[d] != 0) begin n_bad++; $display("FAIL b2b_interval dut%0d got %0d bad want 0", d, bad_iv[d]); end
      n_cmp++;
      if (nresp[d] != acc[d] || bad_dup[d] != 0) begin
        n_bad++; $display("FAIL b2b_resp_count dut%0d got %0d (+%0d extra) want %0d", d, nresp[d], bad_dup[d], acc[d]);
      end
      n_cmp++;
      if (bad_rd[d] != 0) begin n_bad++; $display("FAIL b2b_rdata dut%0d got %0d bad want 0", d, bad_rd[d]); end
    end
    idle_inputs();
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) begin mb[a] = 8'h00; kn[a] = 1'b0; end
    sw_in = 32'h0;
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_latency();
    test_byte_lanes();
    test_io_map();
    test_faults();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lsu_mmio_param.md
LSU_MMIO_PARAM -- requirements
Module: lsu_mmio_param

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, byte-address width.
REQ-002 SHALL have parameter DMEM_WORDS, default 256, 32-bit data-memory words mapped at byte 0x000 upward; DMEM_WORDS*4 <= 0x400.
REQ-003 SHALL have parameter NUM_HEX, default 8, range 1..8, number of hex output registers.
REQ-004 SHALL have parameter WAIT_CYCLES, default 1, range 0..15, wait states per access.
REQ-005 SHALL have ports, one per line, as follows:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when both high.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal.
- req_unsigned  in  1  zero-extend loads.
- req_wdata  in  32  store data, LSB-aligned.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  extended load data.
- resp_err  out  1  access fault.
- sw  in  32  switch inputs.
- io_ledr, io_ledg, io_lcd  out  32 each  output registers.
- io_hex  out  NUM_HEX*32  hex registers; hex i occupies bits [32i+31:32i].

Function
REQ-006 SHALL use the following address map (addr = req_addr):
- DMEM: 0x000 to DMEM_WORDS*4-1.
- ledr: 0x400.
- ledg: 0x410.
- hex i: 0x420+4i, for i < NUM_HEX.
- lcd: 0x440.
- sw: 0x500, read-only.
- All other addresses are unmapped.
REQ-007 SHALL implement FSM states IDLE, WAIT and RESP; req_ready = 1 only in IDLE.
REQ-008 SHALL latch req_we, addr, size, unsigned and wdata on acceptance (IDLE & req_valid).
REQ-009 On acceptance, SHALL move IDLE->WAIT if WAIT_CYCLES > 0, else IDLE->RESP.
REQ-010 SHALL hold WAIT for exactly WAIT_CYCLES cycles using a down-counter, then move to RESP.
REQ-011 SHALL hold RESP for one cycle with resp_valid = 1, then return to IDLE; back-to-back requests therefore accept every WAIT_CYCLES+2 cycles.
REQ-012 SHALL assert resp_valid exactly WAIT_CYCLES+1 clock edges after the accepting edge.
REQ-013 SHALL keep resp_rdata and resp_err at 0 whenever resp_valid = 0.
REQ-014 Store commit SHALL occur on the edge entering RESP; only the addressed byte lanes change (byte lane = addr[1:0], half lane = addr[1]).
REQ-015 Loads SHALL read the target word on the edge entering RESP, including sw and output registers (readback of current value).
REQ-016 Loads SHALL select the lane by addr[1:0] and sign-extend unless req_unsigned = 1; a word load ignores req_unsigned.
REQ-017 Misalignment SHALL be detected for half with addr[0]=1 and word with addr[1:0]!=0.
REQ-018 Misaligned, size=11, unmapped, or store-to-sw requests SHALL give resp_err = 1 and resp_rdata = 0, with no state changed.
REQ-019 Loads from output registers SHALL have no side effects.
REQ-020 req_valid in WAIT or RESP SHALL be ignored (not queued).
REQ-021 Input changes after acceptance SHALL not affect the in-flight access.

Reset
REQ-022 On rst = 0: FSM -> IDLE, counter = 0, resp_valid = resp_rdata = resp_err = 0, and io_ledr/ledg/lcd/hex = 0 immediately (asynchronous).
REQ-023 DMEM contents SHALL NOT be reset; loads before first write are undefined.
REQ-024 Reset asserted in WAIT SHALL abort the access with no store commit; first req_ready = 1 on the first edge after rst deasserts.

Verification
REQ-025 Reset: assert rst = 0 mid-WAIT of a store of 0x12345678 to 0x400 -> io_ledr = 0, no resp_valid, req_ready = 1 after release.
REQ-026 Latency: for WAIT_CYCLES = 0, 1 and 3, sw 0xDEADBEEF @0x010 then lw @0x010 -> resp_valid exactly 1/2/4 edges after acceptance, rdata = 0xDEADBEEF, err = 0.
REQ-027 Byte lanes: sb 0x80 @0x013 over 0x11223344 -> lw = 0x80223344, lb @0x013 = 0xFFFFFF80, lbu = 0x00000080, lh @0x012 = 0xFFFF8022.
REQ-028 IO map: sw 0x0000003F @0x42C -> io_hex[127:96] = 0x3F and others unchanged; lw @0x500 with sw = 0xA5A5A5A5 -> rdata = 0xA5A5A5A5.
REQ-029 Faults: lw @0x402, sh @0x011, sw @0x500, lw @0x600 -> each err = 1, rdata = 0, outputs and DMEM unchanged.
REQ-030 Handshake: hold req_valid high continuously with distinct addresses -> exactly one acceptance per WAIT_CYCLES+2 cycles, no drops of accepted requests, no duplicate responses.
